// File: rtl/counter_pkg.sv
// Shared encodings for the N-channel timer/counter.
package counter_pkg;

  // Counting modes held in control word bits [1:0].
  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_SQUARE   = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  // Control word bit positions.
  localparam int unsigned CTRL_EN = 2;
  localparam int unsigned CTRL_IE = 3;

  // Field layout of the 4 meaningful control bits, MSB first.
  typedef struct packed {
    logic       ie;
    logic       en;
    logic [1:0] mode;
  } ctrl_t;

  // A channel accepts count events only when enabled, in a real mode, with a non-zero reload.
  function automatic logic chan_active(input ctrl_t ctrl, input logic reload_nz);
    return ctrl.en && (ctrl.mode != MODE_RSVD) && reload_nz;
  endfunction

endpackage

// File: rtl/counter_chan.sv
// One timer channel: tick edge detect, count/reload/control registers and terminal output.
module counter_chan
  import counter_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic             ctrl_sel_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] count_o,
  output logic             out_o,
  output logic             terminal_o,
  output logic             irq_en_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;
  logic [Width-1:0] reload_q, reload_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             tick_q;
  logic             out_q, out_d;
  logic             terminal;
  logic             tick_evt;
  logic             active;

  assign tick_evt = tick_i & ~tick_q;
  assign active   = chan_active(ctrl_q, reload_q != '0);

  // Next-state: bus writes take priority over count events in the same cycle.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    ctrl_d   = ctrl_q;
    out_d    = out_q;
    terminal = 1'b0;

    // Periodic output is a single-clk pulse, so it falls unless re-fired below.
    if (ctrl_q.mode == MODE_PERIODIC) begin
      out_d = 1'b0;
    end

    if (we_i) begin
      if (ctrl_sel_i) begin
        ctrl_d = ctrl_t'(wdata_i[3:0]);
        if (wdata_i[1:0] != ctrl_q.mode) begin
          out_d   = 1'b0;
          count_d = reload_q;
        end
      end else begin
        reload_d = wdata_i;
        count_d  = wdata_i;
        out_d    = 1'b0;
      end
    end else if (tick_evt && active) begin
      case (ctrl_q.mode)
        MODE_ONESHOT: begin
          if (count_q != '0) begin
            count_d = count_q - One;
            if (count_q == One) begin
              out_d    = 1'b1;
              terminal = 1'b1;
            end
          end
        end
        MODE_PERIODIC: begin
          if (count_q == One) begin
            count_d  = reload_q;
            out_d    = 1'b1;
            terminal = 1'b1;
          end else if (count_q != '0) begin
            count_d = count_q - One;
          end else begin
            // Never wrap below zero: restart the period instead.
            count_d = reload_q;
          end
        end
        MODE_SQUARE: begin
          if (count_q == One) begin
            count_d  = reload_q;
            out_d    = ~out_q;
            terminal = 1'b1;
          end else if (count_q != '0) begin
            count_d = count_q - One;
          end else begin
            count_d = reload_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      reload_q <= '0;
      ctrl_q   <= '0;
      tick_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      tick_q   <= tick_i;
      out_q    <= out_d;
    end
  end

  assign count_o    = count_q;
  assign out_o      = out_q;
  assign terminal_o = terminal;
  assign irq_en_o   = ctrl_q.ie;

endmodule

// File: rtl/counter_n_io.sv
// N-channel programmable timer/counter: write decode, pending-interrupt register, read-back mux.
module counter_n_io
  import counter_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CHW   = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   tick,
  input  logic             counter_we,
  input  logic             counter_ctrl,
  input  logic [CHW-1:0]   counter_ch,
  input  logic [WIDTH-1:0] counter_val,
  input  logic [CHW-1:0]   rd_ch,
  input  logic [NCH-1:0]   irq_clr,
  output logic [NCH-1:0]   counter_out,
  output logic [WIDTH-1:0] counter_rd,
  output logic [NCH-1:0]   irq_pending,
  output logic             irq
);

  logic [WIDTH-1:0] count [NCH];
  logic [NCH-1:0]   we_ch;
  logic [NCH-1:0]   terminal;
  logic [NCH-1:0]   irq_en;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [WIDTH-1:0] rd_q, rd_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign we_ch[i] = counter_we && (counter_ch == CHW'(i));

    counter_chan #(
      .Width(WIDTH)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .tick_i     (tick[i]),
      .we_i       (we_ch[i]),
      .ctrl_sel_i (counter_ctrl),
      .wdata_i    (counter_val),
      .count_o    (count[i]),
      .out_o      (counter_out[i]),
      .terminal_o (terminal[i]),
      .irq_en_o   (irq_en[i])
    );
  end

  // Clear first, then set, so a terminal coinciding with a clear leaves the flag pending.
  always_comb begin
    pending_d = pending_q & ~irq_clr;
    pending_d = pending_d | (terminal & irq_en);
  end

  // Read-back selects the pre-update count; unimplemented channel indices read as zero.
  always_comb begin
    rd_d = '0;
    if (int'(rd_ch) < int'(NCH)) begin
      rd_d = count[rd_ch];
    end
  end

  // Pending flags and registered read-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      rd_q      <= '0;
    end else begin
      pending_q <= pending_d;
      rd_q      <= rd_d;
    end
  end

  assign irq_pending = pending_q;
  assign irq         = |pending_q;
  assign counter_rd  = rd_q;

endmodule

// File: doc/counter_n_io.md
Name: counter_n_io

Overview:
- Parametrised N-channel programmable timer/counter for the SOC I/O bus.
- Successor to the fixed 3-channel counter. Adds per-channel control words, three counting modes, a pending-interrupt register and a registered read-back mux.
- Sits behind the MIO bus decoder. Counts on prescaled tick inputs taken from the clock divider. Drives the CPU interrupt line and the 7-segment debug data mux.

Parameters:
- NCH, 4, number of channels (2..16).
- WIDTH, 32, counter and reload width in bits.
- CHW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  NCH  per-channel count clock (divider bits), level, sampled in the clk domain.
- counter_we  in  1  bus write strobe, one clk wide.
- counter_ctrl  in  1  1 = write control word, 0 = write reload value.
- counter_ch  in  CHW  channel addressed by a write.
- counter_val  in  WIDTH  write data.
- rd_ch  in  CHW  channel selected for read-back.
- irq_clr  in  NCH  per-channel pending-clear strobes.
- counter_out  out  NCH  per-channel terminal output.
- counter_rd  out  WIDTH  current count of rd_ch, registered.
- irq_pending  out  NCH  pending interrupt flags.
- irq  out  1  OR of irq_pending.

Behaviour:
- Reset (rst=1 at an edge):
  - all counts = 0, reload = 0, ctrl = 0 (disabled, mode 0), tick_d = 0;
  - counter_out = 0, counter_rd = 0, irq_pending = 0, irq = 0.
- Control word fields: [1:0] mode, [2] enable, [3] irq_en. Bits [WIDTH-1:4] are ignored and read as 0 internally.
- Modes:
  - 0 ONESHOT
  - 1 PERIODIC
  - 2 SQUARE
  - 3 reserved, which behaves as disabled (count held, output held).
- Tick detection: tick_d[i] <= tick[i]. A count event is tick[i] & ~tick_d[i], i.e. one event per rising edge of tick. Events are ignored while enable=0, while reload=0, and in mode 3.
- Reload write (counter_ctrl=0):
  - reload[ch] <= val and count[ch] <= val;
  - counter_out[ch] <= 0;
  - ONESHOT re-arms;
  - irq_pending is unaffected.
- Control write (counter_ctrl=1):
  - ctrl[ch] <= val[3:0];
  - count and output are unchanged, except that a mode change forces counter_out[ch] <= 0 and count <= reload.
- ONESHOT, on each event with count != 0:
  - count decrements;
  - on the 1->0 transition: counter_out <= 1 (held), and terminal fires;
  - at count 0 the channel stops; further events are ignored.
- PERIODIC, on each event:
  - if count == 1: count <= reload, counter_out is high for exactly one clk, terminal fires;
  - otherwise count decrements.
- SQUARE, on each event:
  - if count == 1: count <= reload, counter_out toggles, terminal fires;
  - the output period is therefore 2*reload ticks.
- Terminal: if irq_en, irq_pending[i] <= 1 in the same edge as the output change.
- Simultaneous events:
  - write and tick on the same channel and cycle: the write wins and the tick event is dropped;
  - irq_clr[i] and terminal in the same cycle: set wins, pending stays 1;
  - writes to other channels never disturb a counting channel.
- Read-back: counter_rd <= count[rd_ch]. Latency is 1 clk and reflects the count before the current edge's update.
- Arithmetic: unsigned, WIDTH bits, with no wrap below 0 in any mode.
- Mid-operation reset: all state returns to reset values at that edge and the block restarts counting only after new writes.
- irq = |irq_pending, combinational from registers.

Decomposition:
- Package counter_pkg:
  - mode encoding constants (MODE_ONESHOT=2'd0, MODE_PERIODIC=2'd1, MODE_SQUARE=2'd2, MODE_RSVD=2'd3);
  - control bit positions (CTRL_EN=2, CTRL_IE=3).
- Sub-module counter_chan, one instance per channel via generate:
  - holds count, reload, ctrl, tick_d and out;
  - exports a terminal pulse.
- Top level holds the write decode, the irq_pending register and the read mux.

Test Plan:
- Reset, then read all channels -> counter_out=0, counter_rd=0, irq=0.
- ch0: reload=3, ctrl=0xC (ONESHOT, en, ie), 3 tick edges:
  - counter_out[0] rises on the 3rd edge and stays high;
  - irq_pending=0001;
  - a 4th edge leaves count=0;
  - irq_clr[0] -> irq=0.
- ch1: reload=2, ctrl=0x5 (PERIODIC, en), 6 tick edges -> 1-clk out pulses after edges 2, 4, 6; count sequence 2,1,2,1,2,1,2; irq stays 0 (ie=0).
- ch2: reload=1, ctrl=0x6 (SQUARE, en), 4 edges -> out toggles 1,0,1,0.
- ch3: reload write coincident with a tick edge -> count equals the written value with no decrement.
- ch0 terminal coincident with irq_clr[0] -> pending remains 1.
- ch1 (reload=5, ctrl=0x5, counting): assert rst mid-count -> all state cleared; with no new writes, further tick edges leave count=0.
